// File: rtl/axi_slave_mem.sv
// AXI slave memory: independent write and read burst engines sharing one word array.
// Supports FIXED/INCR/WRAP bursts, narrow sizes and SLVERR on out-of-range or illegal requests.
module axi_slave_mem #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADD_WIDTH  = 32,
  parameter int unsigned          ID_WIDTH   = 8,
  parameter int unsigned          MEM_DEPTH  = 1024,
  parameter logic [ADD_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADD_WIDTH-1:0]    awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADD_WIDTH-1:0]    araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arlock,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LNB = $clog2(NB);
  localparam int unsigned IW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADD_WIDTH-1:0] next_addr(input logic [ADD_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADD_WIDTH-1:0] step, aligned, wmask;
    step    = ADD_WIDTH'(1) << size;
    aligned = a & ~(step - ADD_WIDTH'(1));
    wmask   = (ADD_WIDTH'(len) + ADD_WIDTH'(1)) * step - ADD_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~wmask) | ((aligned + step) & wmask);
      default: next_addr = aligned + step;
    endcase
  endfunction

  function automatic logic bad_req(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    bad_req = (size > 3'(LNB)) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Borrow bit of the widened subtraction flags addresses below the base.
  function automatic logic out_of_range(input logic [ADD_WIDTH-1:0] a);
    logic [ADD_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    out_of_range = off[ADD_WIDTH] || ((off[ADD_WIDTH-1:0] >> LNB) >= ADD_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADD_WIDTH-1:0] a);
    word_idx = IW'((a - BASE_ADDR) >> LNB);
  endfunction

  // Write channel
  w_state_t             w_state;
  logic [ADD_WIDTH-1:0] w_addr;
  logic [ID_WIDTH-1:0]  w_id;
  logic [7:0]           w_len, w_cnt;
  logic [2:0]           w_size;
  logic [1:0]           w_burst;
  logic                 w_bad, w_err;
  logic                 w_fire, w_last, w_drop, w_beat_err;

  assign w_fire     = wvalid & wready;
  assign w_last     = (w_cnt == w_len);
  assign w_drop     = w_bad | out_of_range(w_addr);
  assign w_beat_err = w_drop | (wlast != w_last);

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_addr  <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid && awready) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_bad   <= bad_req(awlen, awsize, awburst);
          awready <= 1'b0;
          wready  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | w_beat_err;
          if (w_last) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bid     <= w_id;
            bresp   <= (w_err | w_beat_err) ? 2'b10 : 2'b00;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset; committed data survives an areset pulse.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_drop) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read channel
  r_state_t              r_state;
  logic [ADD_WIDTH-1:0]  r_addr, r_nxt, r_beat_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_bad, r_beat_bad, r_beat_err;
  logic [DATA_WIDTH-1:0] r_beat_data;

  assign r_nxt = next_addr(r_addr, r_len, r_size, r_burst);

  // Address of the beat to be registered at the next edge: first beat or successor.
  always_comb begin
    r_beat_addr = r_nxt;
    r_beat_bad  = r_bad;
    if (r_state == R_IDLE) begin
      r_beat_addr = araddr;
      r_beat_bad  = bad_req(arlen, arsize, arburst);
    end
  end

  assign r_beat_err  = r_beat_bad | out_of_range(r_beat_addr);
  assign r_beat_data = r_beat_err ? '0 : mem[word_idx(r_beat_addr)];

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid && arready) begin
          rid     <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          r_bad   <= r_beat_bad;
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rlast   <= (arlen == 8'd0);
          rdata   <= r_beat_data;
          rresp   <= r_beat_err ? 2'b10 : 2'b00;
          r_state <= R_DATA;
        end
        R_DATA: if (rvalid && rready) begin
          if (rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_nxt;
            r_cnt  <= r_cnt + 8'd1;
            rlast  <= ((r_cnt + 8'd1) == r_len);
            rdata  <= r_beat_data;
            rresp  <= r_beat_err ? 2'b10 : 2'b00;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Lock bits and wid carry no behaviour here.
  logic unused_ok;
  assign unused_ok = ^{wid, awlock, arlock};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized scoreboard bench for axi_slave_mem against a byte-lane array model.
`timescale 1ns/1ps
module tb_axi_slave_mem;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NB    = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic [7:0] awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0] wstrb;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.DATA_WIDTH(32), .ADD_WIDTH(32), .ID_WIDTH(8), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready));

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int n_checks = 0;
  int n_fail = 0;
  int b_done = 0;
  int r_done = 0;
  bit hold_b = 1'b0;
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  bit r_stall = 1'b0;
  logic [31:0] r_pd = '0;
  logic r_pl = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s at %0t", nm, $time);
  endtask

  // Reference model: AXI beat address rules in plain arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint step, al, wsz, base;
    step = longint'(1) << size;
    al = (longint'(a) / step) * step;
    if (i == 0 || burst == 0) return a;
    if (burst == 2) begin
      wsz = longint'(len + 1) * step;
      base = (al / wsz) * wsz;
      return 32'(base + ((al - base) + longint'(i) * step) % wsz);
    end
    return 32'(al + longint'(i) * step);
  endfunction

  function automatic bit illegal(input int len, input int size, input int burst);
    return size > 2 || burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic bit oor(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return off < 0 || off / NB >= DEPTH;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / NB);
  endfunction

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit bad_last);
    bit ill, err;
    logic [31:0] a;
    int target, cyc;
    ill = illegal(len, size, burst);
    err = ill || bad_last;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (!ill) begin
        if (oor(a)) err = 1'b1;
        else for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[widx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    b_q.push_back('{id, err ? 2'b10 : 2'b00});
    target = b_done + 1;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awlock = 1'($urandom % 2); awvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!awready && cyc < 100) begin @(negedge aclk); cyc++; end
    if (!awready) timeout("aw_handshake");
    @(posedge aclk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom % 4 == 0) begin wvalid = 1'b0; @(posedge aclk); #1; end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wid = 8'($urandom);
      wlast = bad_last ? (i != len) : (i == len);
      cyc = 0;
      @(negedge aclk);
      while (!wready && cyc < 100) begin @(negedge aclk); cyc++; end
      if (!wready) timeout("w_handshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    cyc = 0;
    while (b_done < target && cyc < 300) begin @(negedge aclk); cyc++; end
    if (b_done < target) timeout("b_response");
    @(posedge aclk); #1;
  endtask

  task automatic push_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
    bit ill;
    logic [31:0] a;
    ill = illegal(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (ill || oor(a)) r_q.push_back('{id, 32'h0, 2'b10, i == len});
      else r_q.push_back('{id, mdl[widx(a)], 2'b00, i == len});
    end
  endtask

  task automatic ar_issue(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    int cyc;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arlock = 1'($urandom % 2); arvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!arready && cyc < 100) begin @(negedge aclk); cyc++; end
    if (!arready) timeout("ar_handshake");
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    int target, cyc;
    push_read(id, addr, len, size, burst);
    target = r_done + len + 1;
    ar_issue(id, addr, len, size, burst);
    cyc = 0;
    while (r_done < target && cyc < 40 * (len + 1) + 100) begin @(negedge aclk); cyc++; end
    if (r_done < target) timeout("r_beats");
    @(posedge aclk); #1;
  endtask

  task automatic fill(input logic [31:0] d0, input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) begin wd[i] = d0 + 32'(i); ws[i] = s; end
  endtask

  // Ready drivers
  initial begin
    bready = 1'b0; rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bready = hold_b ? 1'b0 : ($urandom % 3 != 0);
      rready = ($urandom % 3 != 0);
    end
  end

  // Write response monitor
  initial begin
    b_exp_t e;
    forever begin
      @(negedge aclk);
      if (areset && bvalid && bready) begin
        if (b_q.size() == 0) timeout("b_unexpected");
        else begin
          e = b_q.pop_front();
          chk("bid", 64'(bid), 64'(e.id));
          chk("bresp", 64'(bresp), 64'(e.resp));
        end
        b_done++;
      end
    end
  end

  // Read data monitor, including stability while stalled
  initial begin
    r_exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset) r_stall = 1'b0;
      else begin
        if (r_stall) begin
          chk("r_hold_valid", 64'(rvalid), 64'(1));
          chk("r_hold_data", 64'(rdata), 64'(r_pd));
          chk("r_hold_last", 64'(rlast), 64'(r_pl));
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) timeout("r_unexpected");
          else begin
            e = r_q.pop_front();
            chk("rid", 64'(rid), 64'(e.id));
            chk("rdata", 64'(rdata), 64'(e.data));
            chk("rresp", 64'(rresp), 64'(e.resp));
            chk("rlast", 64'(rlast), 64'(e.last));
          end
          r_done++;
        end
        r_stall = rvalid && !rready;
        r_pd = rdata;
        r_pl = rlast;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, len, size, burst, target;
    logic [31:0] addr;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0; arvalid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_awready", 64'(awready), 64'(1));
    chk("rst_arready", 64'(arready), 64'(1));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rlast", 64'(rlast), 64'(0));
    chk("rst_bid_bresp", 64'({bid, bresp}), 64'(0));
    chk("rst_rid_rdata_rresp", 64'({rid, rdata, rresp}), 64'(0));
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1;

    // Known contents everywhere
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(8'(k), 32'(k * 1024), 255, 2, 1, 1'b0);
    end

    // Single write and readback
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(8'h11, 32'h10, 0, 2, 1, 1'b0);
    axi_read(8'h12, 32'h10, 0, 2, 1);

    // INCR burst with bready held low for 5 cycles
    fill(32'd1, 4, 4'hF);
    hold_b = 1'b1; bready = 1'b0;
    fork
      axi_write(8'h21, 32'h100, 3, 2, 1, 1'b0);
      begin
        cyc = 0;
        @(negedge aclk);
        while (!bvalid && cyc < 200) begin @(negedge aclk); cyc++; end
        if (!bvalid) timeout("bvalid_rise");
        repeat (5) begin
          @(negedge aclk);
          chk("bhold_valid", 64'(bvalid), 64'(1));
          chk("bhold_id_resp", 64'({bid, bresp}), 64'({8'h21, 2'b00}));
        end
        hold_b = 1'b0;
      end
    join
    axi_read(8'h22, 32'h100, 3, 2, 1);

    // WRAP placement, read back both wrapped and linearly
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(8'h31, 32'h18, 3, 2, 2, 1'b0);
    axi_read(8'h32, 32'h18, 3, 2, 2);
    axi_read(8'h33, 32'h10, 3, 2, 1);

    // Partial strobes, FIXED burst, narrow byte beats
    fill(32'h0, 1, 4'hF);
    axi_write(8'h41, 32'h40, 0, 2, 1, 1'b0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0101;
    axi_write(8'h42, 32'h40, 0, 2, 1, 1'b0);
    axi_read(8'h43, 32'h40, 0, 2, 1);
    fill(32'hA0, 4, 4'hF);
    axi_write(8'h44, 32'h20, 3, 2, 0, 1'b0);
    axi_read(8'h45, 32'h20, 0, 2, 1);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11223344 * 32'(i + 1); ws[i] = 4'(1 << i); end
    axi_write(8'h46, 32'h70, 3, 0, 1, 1'b0);
    axi_read(8'h47, 32'h70, 0, 2, 0);

    // Error paths
    fill(32'h5A5A0000, 1, 4'hF);
    axi_write(8'h51, BASE + 32'(DEPTH * NB), 0, 2, 1, 1'b0);
    axi_read(8'h52, 32'h0, 0, 2, 1);
    axi_read(8'h53, 32'h0, 3, 3, 1);
    axi_read(8'h54, BASE + 32'(DEPTH * NB), 1, 2, 1);
    axi_read(8'h55, 32'h0, 1, 2, 3);
    fill(32'h77, 3, 4'hF);
    axi_write(8'h56, 32'h80, 2, 2, 2, 1'b0);
    axi_read(8'h57, 32'h80, 2, 2, 1);
    fill(32'h99, 2, 4'hF);
    axi_write(8'h58, 32'h60, 1, 2, 1, 1'b1);
    axi_read(8'h59, 32'h60, 1, 2, 1);
    fill(32'hCC, 2, 4'hF);
    axi_write(8'h5A, BASE + 32'(DEPTH * NB) - 32'd4, 1, 2, 1, 1'b0);
    axi_read(8'h5B, BASE + 32'(DEPTH * NB) - 32'd4, 1, 2, 1);

    // Reset in the middle of a len=7 read
    push_read(8'h61, 32'h100, 7, 2, 1);
    target = r_done + 2;
    ar_issue(8'h61, 32'h100, 7, 2, 1);
    cyc = 0;
    while (r_done < target && cyc < 200) begin @(negedge aclk); cyc++; end
    if (r_done < target) timeout("r_before_reset");
    @(posedge aclk); #2 areset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid), 64'(0));
    chk("mid_rst_rlast", 64'(rlast), 64'(0));
    chk("mid_rst_arready", 64'(arready), 64'(1));
    chk("mid_rst_rdata", 64'(rdata), 64'(0));
    r_q.delete();
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1 areset = 1'b1;
    @(negedge aclk);
    chk("post_rst_arready", 64'(arready), 64'(1));
    chk("post_rst_rvalid", 64'(rvalid), 64'(0));
    @(posedge aclk); #1;
    axi_read(8'h62, 32'h10, 0, 2, 1);
    axi_read(8'h63, 32'h100, 3, 2, 1);

    // Randomized traffic, sometimes with both channels busy together
    for (int it = 0; it < 60; it++) begin
      size = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
      burst = ($urandom % 16 == 0) ? 3 : int'($urandom % 3);
      if (burst == 2 && $urandom % 5 != 0) begin
        case ($urandom % 4) 0: len = 1; 1: len = 3; 2: len = 7; default: len = 15; endcase
      end else len = int'($urandom % 8);
      addr = 32'($urandom % 4200) & ~((32'd1 << size) - 32'd1);
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      if (it % 5 == 4) begin
        fork
          axi_write(8'($urandom), 32'h200 + 32'(4 * ($urandom % 32)), len % 8, 2, 1, 1'b0);
          axi_read(8'($urandom), 32'h300, 7, 2, 1);
        join
      end else begin
        axi_write(8'($urandom), addr, len, size, burst, 1'b0);
        axi_read(8'($urandom), addr, len, size, burst);
      end
    end

    repeat (5) @(negedge aclk);
    chk("b_queue_drained", 64'(b_q.size()), 64'(0));
    chk("r_queue_drained", 64'(r_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
